// File: rtl/btn_conditioner.sv
// Two-channel push-button front end: 2-flop synchroniser, debounce FSM and
// registered press pulses with same-cycle conflict rejection. Optional
// auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_in,
    input  logic b0_raw,
    input  logic b1_raw,
    output logic b0_pulse,
    output logic b1_pulse,
    output logic b0_level,
    output logic b1_level,
    output logic conflict
);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(32 * DEBOUNCE_CYCLES + 1);
    localparam int CW    = (RPT_W > CNT_W) ? RPT_W : CNT_W;
    localparam logic [CW-1:0] RPT_LAST   = CW'(32 * DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_RELOAD = CW'(24 * DEBOUNCE_CYCLES);
`else
    localparam int CW = CNT_W;
`endif
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    state_e [1:0]        state_q, state_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [1:0]          level_q, level_d;
    logic [1:0]          pulse_q, pulse_d;
    logic                conflict_q, conflict_d;
    logic [1:0]          accept_s;

    // Next-state logic for both channel FSMs and the output stage.
    always_comb begin
        sync1_d = {b1_raw, b0_raw};
        sync2_d = sync1_q;
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch]  = state_q[ch];
            cnt_d[ch]    = cnt_q[ch];
            level_d[ch]  = level_q[ch];
            accept_s[ch] = 1'b0;
            case (state_q[ch])
                IDLE: begin
                    level_d[ch] = 1'b0;
                    if (sync2_q[ch]) begin
                        state_d[ch] = PRESS_WAIT;
                        cnt_d[ch]   = CNT_ONE;
                    end else begin
                        cnt_d[ch]   = CNT_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = CNT_ZERO;
                    end else if (cnt_q[ch] == DB_LAST) begin
                        state_d[ch]  = PRESSED;
                        cnt_d[ch]    = CNT_ZERO;
                        level_d[ch]  = 1'b1;
                        accept_s[ch] = 1'b1;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    level_d[ch] = 1'b1;
                    if (!sync2_q[ch]) begin
                        state_d[ch] = RELEASE_WAIT;
                        cnt_d[ch]   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                    // cnt doubles as the held-time counter; reload gives the 8x period.
                    end else if (cnt_q[ch] == RPT_LAST) begin
                        accept_s[ch] = 1'b1;
                        cnt_d[ch]    = RPT_RELOAD;
                    end else begin
                        cnt_d[ch]    = cnt_q[ch] + CNT_ONE;
                    end
`else
                    end else begin
                        cnt_d[ch]   = CNT_ZERO;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = PRESSED;
                        cnt_d[ch]   = CNT_ZERO;
                    end else if (cnt_q[ch] == DB_LAST) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = CNT_ZERO;
                        level_d[ch] = 1'b0;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = CNT_ZERO;
                    level_d[ch] = 1'b0;
                end
            endcase
        end
        // Simultaneous accepts are swallowed so the lock never sees both buttons.
        if (accept_s == 2'b11) begin
            pulse_d    = 2'b00;
            conflict_d = 1'b1;
        end else begin
            pulse_d    = accept_s;
            conflict_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            state_q    <= {IDLE, IDLE};
            cnt_q      <= '0;
            level_q    <= 2'b00;
            pulse_q    <= 2'b00;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            conflict_q <= conflict_d;
        end
    end

    assign b0_pulse = pulse_q[0];
    assign b1_pulse = pulse_q[1];
    assign b0_level = level_q[0];
    assign b1_level = level_q[1];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4.
// Output vector checked each cycle: {b0_pulse, b1_pulse, b0_level, b1_level, conflict}.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic reset_in = 1'b1;
    logic b0_raw = 1'b0;
    logic b1_raw = 1'b0;
    logic b0_pulse, b1_pulse, b0_level, b1_level, conflict;

    int n_cmp = 0;
    int n_err = 0;

    btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .b0_raw   (b0_raw),
        .b1_raw   (b1_raw),
        .b0_pulse (b0_pulse),
        .b1_pulse (b1_pulse),
        .b0_level (b0_level),
        .b1_level (b1_level),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then compare the outputs 1 time unit later.
    task automatic step_chk(input string tag, input logic rst, input logic r0, input logic r1,
                            input logic [4:0] exp);
        reset_in = rst;
        b0_raw   = r0;
        b1_raw   = r1;
        @(posedge clk);
        #1;
        check_eq(tag, {b0_pulse, b1_pulse, b0_level, b1_level, conflict}, exp);
    endtask

    task automatic hold_chk(input string tag, input logic r0, input logic r1, input int n,
                            input logic [4:0] exp);
        for (int i = 0; i < n; i++) begin
            step_chk($sformatf("%s[%0d]", tag, i), 1'b0, r0, r1, exp);
        end
    endtask

    initial begin
        // Reset held 3 cycles with both buttons pressed.
        for (int i = 0; i < 3; i++) step_chk($sformatf("rst[%0d]", i), 1'b1, 1'b1, 1'b1, 5'b00000);
        hold_chk("rst_deb", 1'b1, 1'b0, 5, 5'b00000);
        step_chk("rst_pulse", 1'b0, 1'b1, 1'b0, 5'b10100);
        hold_chk("rst_held", 1'b1, 1'b0, 3, 5'b00100);
        hold_chk("rst_rel", 1'b0, 1'b0, 5, 5'b00100);
        step_chk("rst_rel_fall", 1'b0, 1'b0, 1'b0, 5'b00000);

        // Bounce 1,0,1,0,1 then hold.
        step_chk("bnc0", 1'b0, 1'b1, 1'b0, 5'b00000);
        step_chk("bnc1", 1'b0, 1'b0, 1'b0, 5'b00000);
        step_chk("bnc2", 1'b0, 1'b1, 1'b0, 5'b00000);
        step_chk("bnc3", 1'b0, 1'b0, 1'b0, 5'b00000);
        hold_chk("bnc_hold", 1'b1, 1'b0, 5, 5'b00000);
        step_chk("bnc_pulse", 1'b0, 1'b1, 1'b0, 5'b10100);
        hold_chk("bnc_level", 1'b1, 1'b0, 4, 5'b00100);
        hold_chk("bnc_rel", 1'b0, 1'b0, 5, 5'b00100);
        step_chk("bnc_fall", 1'b0, 1'b0, 1'b0, 5'b00000);

        // b1 held 50 cycles, then release with a 2-cycle glitch.
        hold_chk("b1_deb", 1'b0, 1'b1, 5, 5'b00000);
        step_chk("b1_pulse", 1'b0, 1'b0, 1'b1, 5'b01010);
        hold_chk("b1_held", 1'b0, 1'b1, 44, 5'b00010);
        hold_chk("b1_rel_lo", 1'b0, 1'b0, 2, 5'b00010);
        hold_chk("b1_glitch", 1'b0, 1'b1, 2, 5'b00010);
        hold_chk("b1_rel_final", 1'b0, 1'b0, 5, 5'b00010);
        step_chk("b1_fall", 1'b0, 1'b0, 1'b0, 5'b00000);
        hold_chk("b1_idle", 1'b0, 1'b0, 3, 5'b00000);

        // Both buttons in the same cycle.
        hold_chk("cf_deb", 1'b1, 1'b1, 5, 5'b00000);
        step_chk("cf_flag", 1'b0, 1'b1, 1'b1, 5'b00111);
        step_chk("cf_after", 1'b0, 1'b1, 1'b1, 5'b00110);
        hold_chk("cf_rel", 1'b0, 1'b0, 5, 5'b00110);
        step_chk("cf_fall", 1'b0, 1'b0, 1'b0, 5'b00000);

        // b1 one cycle behind b0: adjacent pulses, no conflict.
        step_chk("adj0", 1'b0, 1'b1, 1'b0, 5'b00000);
        hold_chk("adj_deb", 1'b1, 1'b1, 4, 5'b00000);
        step_chk("adj_p0", 1'b0, 1'b1, 1'b1, 5'b10100);
        step_chk("adj_p1", 1'b0, 1'b1, 1'b1, 5'b01110);
        step_chk("adj_held", 1'b0, 1'b1, 1'b1, 5'b00110);
        hold_chk("adj_rel", 1'b0, 1'b0, 5, 5'b00110);
        step_chk("adj_fall", 1'b0, 1'b0, 1'b0, 5'b00000);

        // Reset after two stable samples; full debounce needed afterwards.
        hold_chk("mid_pre", 1'b1, 1'b0, 4, 5'b00000);
        step_chk("mid_rst", 1'b1, 1'b1, 1'b0, 5'b00000);
        hold_chk("mid_deb", 1'b1, 1'b0, 5, 5'b00000);
        step_chk("mid_pulse", 1'b0, 1'b1, 1'b0, 5'b10100);
        hold_chk("mid_rel", 1'b0, 1'b0, 5, 5'b00100);
        step_chk("mid_fall", 1'b0, 1'b0, 1'b0, 5'b00000);

        // Long hold of b0: single pulse, or auto-repeat pulses when enabled.
        for (int i = 1; i <= 250; i++) begin
            logic p;
            p = (i == 6);
`ifdef BTN_AUTOREPEAT_EN
            p = p | (i == 134) | (i == 166) | (i == 198) | (i == 230);
`endif
            step_chk($sformatf("long[%0d]", i), 1'b0, 1'b1, 1'b0,
                     {p, 1'b0, (i >= 6) ? 1'b1 : 1'b0, 1'b0, 1'b0});
        end
        hold_chk("long_rel", 1'b0, 1'b0, 5, 5'b00100);
        hold_chk("long_idle", 1'b0, 1'b0, 20, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
